// File: rtl/mult_sched_pkg.sv
// Shared types and defaults for the multiplier scheduler.
// Holds the FSM state encoding and the default watchdog limit.
package mult_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } sched_state_e;

  function automatic int timeout_for(input int dw);
    return 2 * dw + 4;
  endfunction

  localparam int DEF_DW      = 8;
  localparam int DEF_TIMEOUT = timeout_for(DEF_DW);

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority pick: first valid bit at or above ptr,
// wrapping, reported as one-hot grant plus index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int          pos;
  logic [IDW-1:0] k;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    k     = '0;
    for (int i = 0; i < NREQ; i++) begin
      pos = int'(ptr) + i;
      if (pos >= NREQ) pos = pos - NREQ;
      k = IDW'(pos);
      if (!any && valid[k]) begin
        any      = 1'b1;
        idx      = k;
        grant[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_sched.sv
// Round-robin front end for one shared shift-add multiplier:
// accept, start, wait for stop or watchdog, return tagged result.
module mult_sched
  import mult_sched_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int D2W     = DW * 2,
  parameter int NREQ    = 4,
  parameter int IDW     = $clog2(NREQ),
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NREQ-1:0]    i_req_valid,
  input  logic [NREQ*DW-1:0] i_req_mltnd,
  input  logic [NREQ*DW-1:0] i_req_mlter,
  output logic [NREQ-1:0]    o_req_ready,
  output logic               o_mul_start,
  output logic [DW-1:0]      o_mul_mltnd,
  output logic [DW-1:0]      o_mul_mlter,
  input  logic [D2W:0]       i_mul_product,
  input  logic               i_mul_stop,
  output logic               o_rsp_valid,
  output logic [IDW-1:0]     o_rsp_id,
  output logic [D2W:0]       o_rsp_product,
  output logic               o_rsp_err,
  input  logic               i_rsp_ready
);

  localparam int TW = $clog2(TIMEOUT + 1);

  sched_state_e   state, state_nx;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt_idx;
  logic [NREQ-1:0] gnt;
  logic           any_vld;
  logic [TW-1:0]  timer;
  logic           tmo_hit;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .valid (i_req_valid),
    .ptr   (ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (any_vld)
  );

  // timer counts cycles since the start pulse (0 in ISSUE)
  assign tmo_hit = (timer == TW'(TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_vld) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (i_mul_stop || tmo_hit) state_nx = RESP;
      RESP:    if (i_rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state         <= IDLE;
      ptr           <= '0;
      timer         <= '0;
      o_req_ready   <= '0;
      o_mul_start   <= 1'b0;
      o_mul_mltnd   <= '0;
      o_mul_mlter   <= '0;
      o_rsp_valid   <= 1'b0;
      o_rsp_id      <= '0;
      o_rsp_product <= '0;
      o_rsp_err     <= 1'b0;
    end else begin
      state       <= state_nx;
      o_req_ready <= '0;
      o_mul_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_vld) begin
            o_req_ready <= gnt;
            o_mul_start <= 1'b1;
            o_mul_mltnd <= i_req_mltnd[gnt_idx*DW +: DW];
            o_mul_mlter <= i_req_mlter[gnt_idx*DW +: DW];
            o_rsp_id    <= gnt_idx;
            timer       <= '0;
            ptr <= (gnt_idx == IDW'(NREQ - 1)) ?
                   '0 : gnt_idx + IDW'(1);
          end
        end
        ISSUE: timer <= timer + TW'(1);
        WAIT: begin
          timer <= timer + TW'(1);
          if (i_mul_stop) begin
            o_rsp_product <= i_mul_product;
            o_rsp_err     <= 1'b0;
            o_rsp_valid   <= 1'b1;
          end else if (tmo_hit) begin
            o_rsp_product <= '0;
            o_rsp_err     <= 1'b1;
            o_rsp_valid   <= 1'b1;
          end
        end
        RESP: if (i_rsp_ready) o_rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
